// File: rtl/branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_resolve
// Description : Fetch-side branch prediction with a direct-mapped BTB that
//               holds 2-bit saturating counters. Execute-side resolution of
//               bne/blt/j/jal/jr/bex, with flush and redirect on mispredict.
// Ports       : i_clock / i_reset      - clock, synchronous active-high reset
//               i_f_pc                 - fetch address for the BTB lookup
//               o_pred_taken/o_pred_pc - prediction returned to fetch
//               i_x_*                  - execute-stage instruction context
//               o_flush/o_redirect_pc  - squash request and correct next PC
//               o_branch_count         - resolved control instructions
//               o_mispredict_count     - number of flushes raised
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_resolve #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [31:0]      i_f_pc,
    output logic             o_pred_taken,
    output logic [31:0]      o_pred_pc,
    input  logic             i_x_valid,
    input  logic             i_stall,
    input  logic [31:0]      i_x_pc,
    input  logic [31:0]      i_x_ir,
    input  logic [31:0]      i_x_sx_imm,
    input  logic [31:0]      i_x_rd,
    input  logic             i_x_neq,
    input  logic             i_x_lt,
    input  logic             i_x_pred_taken,
    input  logic [31:0]      i_x_pred_pc,
    output logic             o_flush,
    output logic [31:0]      o_redirect_pc,
    output logic [CNT_W-1:0] o_branch_count,
    output logic [CNT_W-1:0] o_mispredict_count
);

    localparam logic [4:0]       c_OP_J   = 5'b00001;
    localparam logic [4:0]       c_OP_BNE = 5'b00010;
    localparam logic [4:0]       c_OP_JAL = 5'b00011;
    localparam logic [4:0]       c_OP_JR  = 5'b00100;
    localparam logic [4:0]       c_OP_BLT = 5'b00110;
    localparam logic [4:0]       c_OP_BEX = 5'b10110;
    localparam logic [CNT_W-1:0] c_STAT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // BTB storage
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_cnt    [ENTRIES];

    logic [CNT_W-1:0]   r_branch_count;
    logic [CNT_W-1:0]   r_mispredict_count;

    // ---------------- fetch-side lookup ----------------
    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;

    assign w_f_idx = i_f_pc[IDX_W-1:0];
    assign w_f_tag = i_f_pc[IDX_W+TAG_W-1:IDX_W];
    // Reads the registered table, so a same-cycle update is not visible yet.
    assign w_f_hit = r_valid[w_f_idx] & (r_tag[w_f_idx] == w_f_tag);

    assign o_pred_taken = ~i_reset & w_f_hit & r_cnt[w_f_idx][1];
    assign o_pred_pc    = o_pred_taken ? r_target[w_f_idx] : (i_f_pc + 32'd1);

    // ---------------- execute-side resolution ----------------
    logic [4:0]  w_opcode;
    logic [31:0] w_fall;
    logic [31:0] w_br_target;
    logic [31:0] w_jmp_target;
    logic        w_is_ctrl;
    logic        w_taken;
    logic [31:0] w_target;
    logic [31:0] w_actual_pc;

    assign w_opcode     = i_x_ir[31:27];
    assign w_fall       = i_x_pc + 32'd1;
    assign w_br_target  = w_fall + i_x_sx_imm;
    assign w_jmp_target = {5'b0, i_x_ir[26:0]};

    always_comb begin
        w_is_ctrl = 1'b0;
        w_taken   = 1'b0;
        w_target  = w_fall;
        case (w_opcode)
            c_OP_J, c_OP_JAL: begin
                w_is_ctrl = 1'b1;
                w_taken   = 1'b1;
                w_target  = w_jmp_target;
            end
            c_OP_BNE: begin
                w_is_ctrl = 1'b1;
                w_taken   = i_x_neq;
                w_target  = w_br_target;
            end
            c_OP_BLT: begin
                w_is_ctrl = 1'b1;
                w_taken   = i_x_lt;
                w_target  = w_br_target;
            end
            c_OP_JR: begin
                w_is_ctrl = 1'b1;
                w_taken   = 1'b1;
                w_target  = i_x_rd;
            end
            c_OP_BEX: begin
                w_is_ctrl = 1'b1;
                w_taken   = (i_x_rd != 32'd0);
                w_target  = w_jmp_target;
            end
            default: ;
        endcase
    end

    assign w_actual_pc = w_taken ? w_target : w_fall;

    // Any real, non-stalled instruction whose carried prediction disagrees
    // with the resolved next PC flushes; this also catches aliased
    // non-control hits and stale jr targets.
    logic w_fire;
    assign w_fire        = i_x_valid & ~i_stall & ~i_reset;
    assign o_flush       = w_fire & (i_x_pred_pc != w_actual_pc);
    assign o_redirect_pc = w_actual_pc;

    // ---------------- BTB update ----------------
    logic [IDX_W-1:0] w_x_idx;
    logic [TAG_W-1:0] w_x_tag;
    logic             w_x_hit;
    logic             w_update;
    logic             w_alias;

    assign w_x_idx  = i_x_pc[IDX_W-1:0];
    assign w_x_tag  = i_x_pc[IDX_W+TAG_W-1:IDX_W];
    assign w_x_hit  = r_valid[w_x_idx] & (r_tag[w_x_idx] == w_x_tag);
    assign w_update = w_fire & w_is_ctrl;
    assign w_alias  = w_fire & ~w_is_ctrl & i_x_pred_taken;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid            <= '0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= 2'b01;
            end
        end else begin
            if (w_update) begin
                if (w_x_hit) begin
                    if (w_taken) begin
                        if (r_cnt[w_x_idx] != 2'b11) begin
                            r_cnt[w_x_idx] <= r_cnt[w_x_idx] + 2'd1;
                        end
                        r_target[w_x_idx] <= w_target;
                    end else if (r_cnt[w_x_idx] != 2'b00) begin
                        r_cnt[w_x_idx] <= r_cnt[w_x_idx] - 2'd1;
                    end
                end else if (w_taken) begin
                    // New entries start weakly taken.
                    r_valid[w_x_idx]  <= 1'b1;
                    r_tag[w_x_idx]    <= w_x_tag;
                    r_target[w_x_idx] <= w_target;
                    r_cnt[w_x_idx]    <= 2'b10;
                end
            end

            if (w_alias) begin
                r_valid[w_x_idx] <= 1'b0;
            end

            if (w_update && (r_branch_count != '1)) begin
                r_branch_count <= r_branch_count + c_STAT_ONE;
            end
            if (o_flush && (r_mispredict_count != '1)) begin
                r_mispredict_count <= r_mispredict_count + c_STAT_ONE;
            end
        end
    end

    assign o_branch_count     = r_branch_count;
    assign o_mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_resolve
// Description : Self-checking bench for branch_predict_resolve. Each row of a
//               scenario drives one cycle of stimulus and pushes its expected
//               outputs into a scoreboard, popped and compared mid-cycle.
//               Statistic counters are narrowed to 4 bits so saturation is
//               reachable quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_resolve;

    localparam int         c_CW     = 4;
    localparam logic [4:0] c_OP_NOP = 5'b00000;
    localparam logic [4:0] c_OP_J   = 5'b00001;
    localparam logic [4:0] c_OP_BNE = 5'b00010;
    localparam logic [4:0] c_OP_JAL = 5'b00011;
    localparam logic [4:0] c_OP_JR  = 5'b00100;
    localparam logic [4:0] c_OP_BLT = 5'b00110;
    localparam logic [4:0] c_OP_BEX = 5'b10110;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     f_pc;
    logic            pred_taken;
    logic [31:0]     pred_pc;
    logic            x_valid, stall;
    logic [31:0]     x_pc, x_ir, x_sx_imm, x_rd;
    logic            x_neq, x_lt, x_pred_taken;
    logic [31:0]     x_pred_pc;
    logic            flush;
    logic [31:0]     redirect_pc;
    logic [c_CW-1:0] bcnt, mcnt;

    int n_run  = 0;
    int n_fail = 0;

    branch_predict_resolve #(
        .ENTRIES(16), .IDX_W(4), .TAG_W(8), .CNT_W(c_CW)
    ) dut (
        .i_clock            (clk),
        .i_reset            (rst),
        .i_f_pc             (f_pc),
        .o_pred_taken       (pred_taken),
        .o_pred_pc          (pred_pc),
        .i_x_valid          (x_valid),
        .i_stall            (stall),
        .i_x_pc             (x_pc),
        .i_x_ir             (x_ir),
        .i_x_sx_imm         (x_sx_imm),
        .i_x_rd             (x_rd),
        .i_x_neq            (x_neq),
        .i_x_lt             (x_lt),
        .i_x_pred_taken     (x_pred_taken),
        .i_x_pred_pc        (x_pred_pc),
        .o_flush            (flush),
        .o_redirect_pc      (redirect_pc),
        .o_branch_count     (bcnt),
        .o_mispredict_count (mcnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rst;
        logic [31:0] fpc;
        logic        xv, st;
        logic [4:0]  op;
        logic [31:0] xpc, imm, xrd;
        logic        neq, lt, xpt;
        logic [31:0] xppc;
        logic [26:0] tgt;
        logic        fl;
        logic [31:0] rpc;
        logic        pt;
        logic [31:0] ppc;
        logic [c_CW-1:0] bc, mc;
    } row_t;

    typedef struct {
        string       nm;
        logic        fl;
        logic [31:0] rpc;
        logic        pt;
        logic [31:0] ppc;
        logic [c_CW-1:0] bc, mc;
    } exp_t;

    exp_t sb[$];

    function automatic row_t mk(
        input string nm, input bit r, input logic [31:0] fpc, input bit xv, input bit st,
        input logic [4:0] op, input logic [31:0] xpc, input logic [31:0] imm, input logic [31:0] xrd,
        input bit neq, input bit lt, input bit xpt, input logic [31:0] xppc, input logic [31:0] tgt,
        input bit fl, input logic [31:0] rpc, input bit pt, input logic [31:0] ppc, input int bc, input int mc);
        row_t w;
        w.nm = nm; w.rst = r; w.fpc = fpc; w.xv = xv; w.st = st; w.op = op;
        w.xpc = xpc; w.imm = imm; w.xrd = xrd; w.neq = neq; w.lt = lt; w.xpt = xpt;
        w.xppc = xppc; w.tgt = tgt[26:0]; w.fl = fl; w.rpc = rpc; w.pt = pt; w.ppc = ppc;
        w.bc = bc[c_CW-1:0]; w.mc = mc[c_CW-1:0];
        return w;
    endfunction

    // Drive one cycle of stimulus and enqueue what the outputs must be.
    task automatic drive(input row_t w);
        exp_t e;
        rst = w.rst; f_pc = w.fpc; x_valid = w.xv; stall = w.st;
        x_ir = {w.op, w.tgt}; x_pc = w.xpc; x_sx_imm = w.imm; x_rd = w.xrd;
        x_neq = w.neq; x_lt = w.lt; x_pred_taken = w.xpt; x_pred_pc = w.xppc;
        e.nm = w.nm; e.fl = w.fl; e.rpc = w.rpc; e.pt = w.pt; e.ppc = w.ppc; e.bc = w.bc; e.mc = w.mc;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk("rst_hold", 1, 32'h10, 1, 0, c_OP_BNE, 32'h20, 5, 0, 1, 0, 0, 32'h21, 0, 0, 0, 0, 32'h11, 0, 0));
        rows.push_back(mk("rst_idle", 0, 32'h10, 0, 0, c_OP_NOP, 32'h0, 0, 0, 0, 0, 0, 32'h1, 0, 0, 0, 0, 32'h11, 0, 0));
        foreach (rows[k]) begin
            drive(rows[k]);
            @(negedge clk);
            e = sb.pop_front();
            n_run++; if (flush !== e.fl) begin n_fail++; $display("FAIL %s flush got %0b want %0b", e.nm, flush, e.fl); end
            n_run++; if (pred_taken !== e.pt) begin n_fail++; $display("FAIL %s pred_taken got %0b want %0b", e.nm, pred_taken, e.pt); end
            n_run++; if (pred_pc !== e.ppc) begin n_fail++; $display("FAIL %s pred_pc got %h want %h", e.nm, pred_pc, e.ppc); end
            n_run++; if (bcnt !== e.bc || mcnt !== e.mc) begin n_fail++; $display("FAIL %s counts got %0d/%0d want %0d/%0d", e.nm, bcnt, mcnt, e.bc, e.mc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bne();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk("bne_alloc", 0, 32'h20, 1, 0, c_OP_BNE, 32'h20, 5, 0, 1, 0, 0, 32'h21, 0, 1, 32'h26, 0, 32'h21, 0, 0));
        rows.push_back(mk("bne_pred",  0, 32'h20, 0, 0, c_OP_NOP, 32'h0,  0, 0, 0, 0, 0, 32'h1,  0, 0, 0,      1, 32'h26, 1, 1));
        rows.push_back(mk("bne_nt1",   0, 32'h20, 1, 0, c_OP_BNE, 32'h20, 5, 0, 0, 0, 1, 32'h26, 0, 1, 32'h21, 1, 32'h26, 1, 1));
        rows.push_back(mk("bne_nt2",   0, 32'h20, 1, 0, c_OP_BNE, 32'h20, 5, 0, 0, 0, 0, 32'h21, 0, 0, 0,      0, 32'h21, 2, 2));
        rows.push_back(mk("bne_weak",  0, 32'h20, 0, 0, c_OP_NOP, 32'h0,  0, 0, 0, 0, 0, 32'h1,  0, 0, 0,      0, 32'h21, 3, 2));
        rows.push_back(mk("bne_t_low", 0, 32'h20, 1, 0, c_OP_BNE, 32'h20, 5, 0, 1, 0, 0, 32'h21, 0, 1, 32'h26, 0, 32'h21, 3, 2));
        rows.push_back(mk("bne_floor", 0, 32'h20, 0, 0, c_OP_NOP, 32'h0,  0, 0, 0, 0, 0, 32'h1,  0, 0, 0,      0, 32'h21, 4, 3));
        foreach (rows[k]) begin
            drive(rows[k]);
            @(negedge clk);
            e = sb.pop_front();
            n_run++; if (flush !== e.fl) begin n_fail++; $display("FAIL %s flush got %0b want %0b", e.nm, flush, e.fl); end
            if (e.fl) begin
                n_run++; if (redirect_pc !== e.rpc) begin n_fail++; $display("FAIL %s redirect_pc got %h want %h", e.nm, redirect_pc, e.rpc); end
            end
            n_run++; if (pred_taken !== e.pt) begin n_fail++; $display("FAIL %s pred_taken got %0b want %0b", e.nm, pred_taken, e.pt); end
            n_run++; if (pred_pc !== e.ppc) begin n_fail++; $display("FAIL %s pred_pc got %h want %h", e.nm, pred_pc, e.ppc); end
            n_run++; if (bcnt !== e.bc || mcnt !== e.mc) begin n_fail++; $display("FAIL %s counts got %0d/%0d want %0d/%0d", e.nm, bcnt, mcnt, e.bc, e.mc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jr_bex();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk("jr_alloc",  0, 32'h31, 1, 0, c_OP_JR,  32'h31, 0, 32'h100, 0, 0, 0, 32'h32,  0,     1, 32'h100, 0, 32'h32,  4, 3));
        rows.push_back(mk("jr_pred",   0, 32'h31, 0, 0, c_OP_NOP, 32'h0,  0, 0,       0, 0, 0, 32'h1,   0,     0, 0,       1, 32'h100, 5, 4));
        rows.push_back(mk("jr_retgt",  0, 32'h31, 1, 0, c_OP_JR,  32'h31, 0, 32'h200, 0, 0, 1, 32'h100, 0,     1, 32'h200, 1, 32'h100, 5, 4));
        rows.push_back(mk("jr_newtgt", 0, 32'h31, 0, 0, c_OP_NOP, 32'h0,  0, 0,       0, 0, 0, 32'h1,   0,     0, 0,       1, 32'h200, 6, 5));
        rows.push_back(mk("bex_nt",    0, 32'h42, 1, 0, c_OP_BEX, 32'h42, 0, 0,       0, 0, 0, 32'h43,  32'h50, 0, 0,      0, 32'h43,  6, 5));
        rows.push_back(mk("bex_noall", 0, 32'h42, 0, 0, c_OP_NOP, 32'h0,  0, 0,       0, 0, 0, 32'h1,   0,     0, 0,       0, 32'h43,  7, 5));
        rows.push_back(mk("bex_t",     0, 32'h42, 1, 0, c_OP_BEX, 32'h42, 0, 3,       0, 0, 0, 32'h43,  32'h50, 1, 32'h50, 0, 32'h43,  7, 5));
        rows.push_back(mk("bex_pred",  0, 32'h42, 0, 0, c_OP_NOP, 32'h0,  0, 0,       0, 0, 0, 32'h1,   0,     0, 0,       1, 32'h50,  8, 6));
        foreach (rows[k]) begin
            drive(rows[k]);
            @(negedge clk);
            e = sb.pop_front();
            n_run++; if (flush !== e.fl) begin n_fail++; $display("FAIL %s flush got %0b want %0b", e.nm, flush, e.fl); end
            if (e.fl) begin
                n_run++; if (redirect_pc !== e.rpc) begin n_fail++; $display("FAIL %s redirect_pc got %h want %h", e.nm, redirect_pc, e.rpc); end
            end
            n_run++; if (pred_taken !== e.pt) begin n_fail++; $display("FAIL %s pred_taken got %0b want %0b", e.nm, pred_taken, e.pt); end
            n_run++; if (pred_pc !== e.ppc) begin n_fail++; $display("FAIL %s pred_pc got %h want %h", e.nm, pred_pc, e.ppc); end
            n_run++; if (bcnt !== e.bc || mcnt !== e.mc) begin n_fail++; $display("FAIL %s counts got %0d/%0d want %0d/%0d", e.nm, bcnt, mcnt, e.bc, e.mc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_alias();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk("blt_stall1", 0, 32'h63, 1, 1, c_OP_BLT, 32'h63, 32'h10, 0, 0, 1, 0, 32'h64, 0, 0, 0,      0, 32'h64, 8, 6));
        rows.push_back(mk("blt_stall2", 0, 32'h63, 1, 1, c_OP_BLT, 32'h63, 32'h10, 0, 0, 1, 0, 32'h64, 0, 0, 0,      0, 32'h64, 8, 6));
        rows.push_back(mk("blt_go",     0, 32'h63, 1, 0, c_OP_BLT, 32'h63, 32'h10, 0, 0, 1, 0, 32'h64, 0, 1, 32'h74, 0, 32'h64, 8, 6));
        rows.push_back(mk("blt_pred",   0, 32'h63, 0, 0, c_OP_NOP, 32'h0,  0,      0, 0, 0, 0, 32'h1,  0, 0, 0,      1, 32'h74, 9, 7));
        rows.push_back(mk("alias_hit",  0, 32'h42, 1, 0, c_OP_NOP, 32'h42, 0,      0, 0, 0, 1, 32'h50, 0, 1, 32'h43, 1, 32'h50, 9, 7));
        rows.push_back(mk("alias_inv",  0, 32'h42, 0, 0, c_OP_NOP, 32'h0,  0,      0, 0, 0, 0, 32'h1,  0, 0, 0,      0, 32'h43, 9, 8));
        rows.push_back(mk("nonctl_ok",  0, 32'h42, 1, 0, c_OP_NOP, 32'h44, 0,      0, 0, 0, 0, 32'h45, 0, 0, 0,      0, 32'h43, 9, 8));
        rows.push_back(mk("other_keep", 0, 32'h31, 0, 0, c_OP_NOP, 32'h0,  0,      0, 0, 0, 0, 32'h1,  0, 0, 0,      1, 32'h200, 9, 8));
        foreach (rows[k]) begin
            drive(rows[k]);
            @(negedge clk);
            e = sb.pop_front();
            n_run++; if (flush !== e.fl) begin n_fail++; $display("FAIL %s flush got %0b want %0b", e.nm, flush, e.fl); end
            if (e.fl) begin
                n_run++; if (redirect_pc !== e.rpc) begin n_fail++; $display("FAIL %s redirect_pc got %h want %h", e.nm, redirect_pc, e.rpc); end
            end
            n_run++; if (pred_taken !== e.pt) begin n_fail++; $display("FAIL %s pred_taken got %0b want %0b", e.nm, pred_taken, e.pt); end
            n_run++; if (pred_pc !== e.ppc) begin n_fail++; $display("FAIL %s pred_pc got %h want %h", e.nm, pred_pc, e.ppc); end
            n_run++; if (bcnt !== e.bc || mcnt !== e.mc) begin n_fail++; $display("FAIL %s counts got %0d/%0d want %0d/%0d", e.nm, bcnt, mcnt, e.bc, e.mc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap_tag();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk("wrap_ok",   0, 32'hFFFFFFFF, 1, 0, c_OP_NOP, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0,     0, 32'h0,   9, 8));
        rows.push_back(mk("wrap_bad",  0, 32'hFFFFFFFF, 1, 0, c_OP_NOP, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 0, 1, 32'h0, 0, 32'h0,   9, 8));
        rows.push_back(mk("tag_miss",  0, 32'h131,      0, 0, c_OP_NOP, 32'h0,        0, 0, 0, 0, 0, 32'h1,        0, 0, 0,     0, 32'h132, 9, 9));
        rows.push_back(mk("tag_match", 0, 32'h31,       0, 0, c_OP_NOP, 32'h0,        0, 0, 0, 0, 0, 32'h1,        0, 0, 0,     1, 32'h200, 9, 9));
        foreach (rows[k]) begin
            drive(rows[k]);
            @(negedge clk);
            e = sb.pop_front();
            n_run++; if (flush !== e.fl) begin n_fail++; $display("FAIL %s flush got %0b want %0b", e.nm, flush, e.fl); end
            if (e.fl) begin
                n_run++; if (redirect_pc !== e.rpc) begin n_fail++; $display("FAIL %s redirect_pc got %h want %h", e.nm, redirect_pc, e.rpc); end
            end
            n_run++; if (pred_taken !== e.pt) begin n_fail++; $display("FAIL %s pred_taken got %0b want %0b", e.nm, pred_taken, e.pt); end
            n_run++; if (pred_pc !== e.ppc) begin n_fail++; $display("FAIL %s pred_pc got %h want %h", e.nm, pred_pc, e.ppc); end
            n_run++; if (bcnt !== e.bc || mcnt !== e.mc) begin n_fail++; $display("FAIL %s counts got %0d/%0d want %0d/%0d", e.nm, bcnt, mcnt, e.bc, e.mc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk("jal_alloc", 0, 32'hA4, 1, 0, c_OP_JAL, 32'hA4, 0, 0, 0, 0, 0, 32'hA5, 32'hB0, 1, 32'hB0, 0, 32'hA5, 9, 9));
        rows.push_back(mk("jal_hit",   0, 32'hA4, 1, 0, c_OP_JAL, 32'hA4, 0, 0, 0, 0, 1, 32'hB0, 32'hB0, 0, 0,      1, 32'hB0, 10, 10));
        rows.push_back(mk("j_retgt",   0, 32'hA4, 1, 0, c_OP_J,   32'hA4, 0, 0, 0, 0, 1, 32'hB0, 32'hC0, 1, 32'hC0, 1, 32'hB0, 11, 10));
        rows.push_back(mk("j_pred",    0, 32'hA4, 0, 0, c_OP_NOP, 32'h0,  0, 0, 0, 0, 0, 32'h1,  0,      0, 0,      1, 32'hC0, 12, 11));
        rows.push_back(mk("rst_mid",   1, 32'hD5, 1, 0, c_OP_JAL, 32'hD5, 0, 0, 0, 0, 0, 32'hD6, 32'hE0, 0, 0,      0, 32'hD6, 12, 11));
        rows.push_back(mk("rst_nowr",  0, 32'hD5, 0, 0, c_OP_NOP, 32'h0,  0, 0, 0, 0, 0, 32'h1,  0,      0, 0,      0, 32'hD6, 0, 0));
        rows.push_back(mk("rst_clear", 0, 32'h31, 0, 0, c_OP_NOP, 32'h0,  0, 0, 0, 0, 0, 32'h1,  0,      0, 0,      0, 32'h32, 0, 0));
        foreach (rows[k]) begin
            drive(rows[k]);
            @(negedge clk);
            e = sb.pop_front();
            n_run++; if (flush !== e.fl) begin n_fail++; $display("FAIL %s flush got %0b want %0b", e.nm, flush, e.fl); end
            if (e.fl) begin
                n_run++; if (redirect_pc !== e.rpc) begin n_fail++; $display("FAIL %s redirect_pc got %h want %h", e.nm, redirect_pc, e.rpc); end
            end
            n_run++; if (pred_taken !== e.pt) begin n_fail++; $display("FAIL %s pred_taken got %0b want %0b", e.nm, pred_taken, e.pt); end
            n_run++; if (pred_pc !== e.ppc) begin n_fail++; $display("FAIL %s pred_pc got %h want %h", e.nm, pred_pc, e.ppc); end
            n_run++; if (bcnt !== e.bc || mcnt !== e.mc) begin n_fail++; $display("FAIL %s counts got %0d/%0d want %0d/%0d", e.nm, bcnt, mcnt, e.bc, e.mc); end
            @(posedge clk); #1;
        end
    endtask

    // Every cycle resolves a not-taken bne against a wrong prediction, so
    // both statistics advance together until they pin at all-ones.
    task automatic test_saturate();
        row_t rows[$];
        exp_t e;
        for (int i = 0; i < 20; i++) begin
            rows.push_back(mk($sformatf("sat%0d", i), 0, 32'h200, 1, 0, c_OP_BNE, 32'hF8, 4, 0, 0, 0, 0, 32'h0, 0,
                              1, 32'hF9, 0, 32'h201, (i > 15) ? 15 : i, (i > 15) ? 15 : i));
        end
        foreach (rows[k]) begin
            drive(rows[k]);
            @(negedge clk);
            e = sb.pop_front();
            n_run++; if (flush !== e.fl) begin n_fail++; $display("FAIL %s flush got %0b want %0b", e.nm, flush, e.fl); end
            if (e.fl) begin
                n_run++; if (redirect_pc !== e.rpc) begin n_fail++; $display("FAIL %s redirect_pc got %h want %h", e.nm, redirect_pc, e.rpc); end
            end
            n_run++; if (pred_pc !== e.ppc) begin n_fail++; $display("FAIL %s pred_pc got %h want %h", e.nm, pred_pc, e.ppc); end
            n_run++; if (bcnt !== e.bc || mcnt !== e.mc) begin n_fail++; $display("FAIL %s counts got %0d/%0d want %0d/%0d", e.nm, bcnt, mcnt, e.bc, e.mc); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; f_pc = 32'h10; x_valid = 1'b0; stall = 1'b0;
        x_pc = '0; x_ir = '0; x_sx_imm = '0; x_rd = '0;
        x_neq = 1'b0; x_lt = 1'b0; x_pred_taken = 1'b0; x_pred_pc = '0;
        @(posedge clk); #1;
        test_reset();
        test_bne();
        test_jr_bex();
        test_stall_alias();
        test_wrap_tag();
        test_back_to_back();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
